// File: rtl/ctl_setup_rx_pkg.sv
// Shared USB encodings and types for the EP0 SETUP receiver.
package ctl_setup_rx_pkg;

    localparam logic [1:0] TOK_SETUP = 2'b11;
    localparam logic [1:0] PID_DATA0 = 2'b00;
    localparam logic [1:0] HSK_ACK   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RECV,
        ST_DROP,
        ST_ACK
    } state_t;

    typedef struct packed {
        logic [7:0]  rtype;
        logic [7:0]  rargs;
        logic [15:0] value;
        logic [15:0] index;
        logic [15:0] length;
    } setup_req_t;

    // Byte 0 is bmRequestType; the 16-bit fields arrive LSB first.
    function automatic setup_req_t unpack_req(input logic [7:0][7:0] b);
        setup_req_t r;
        r.rtype  = b[0];
        r.rargs  = b[1];
        r.value  = {b[3], b[2]};
        r.index  = {b[5], b[4]};
        r.length = {b[7], b[6]};
        return r;
    endfunction

endpackage

// File: rtl/ctl_setup_rx.sv
// EP0 SETUP stage receiver: captures the 8-byte DATA0 request,
// commits it on a clean packet and asks the encoder for an ACK.
module ctl_setup_rx
    import ctl_setup_rx_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tok_recv_i,
    input  logic [1:0]  tok_type_i,
    input  logic        crc_err_i,
    input  logic        out_tvalid_i,
    output logic        out_tready_o,
    input  logic        out_tlast_i,
    input  logic [1:0]  out_ttype_i,
    input  logic [7:0]  out_tdata_i,
    output logic        ctl_start_o,
    output logic [7:0]  ctl_rtype_o,
    output logic [7:0]  ctl_rargs_o,
    output logic [15:0] ctl_value_o,
    output logic [15:0] ctl_index_o,
    output logic [15:0] ctl_length_o,
    output logic        hsk_send_o,
    input  logic        hsk_sent_i,
    output logic [1:0]  hsk_type_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [TW-1:0]    tmo_cnt, tmo_nxt;
    logic [3:0]       byte_cnt, byte_nxt;
    logic             crc_seen, crc_nxt;
    logic             pend, pend_nxt;
    logic [7:0][7:0]  shadow, shadow_nxt;
    setup_req_t       req, req_nxt;
    logic             start_nxt, err_nxt;
    logic             setup_tok, beat, take_byte;

    assign setup_tok    = tok_recv_i && (tok_type_i == TOK_SETUP);
    assign out_tready_o = (state == ST_WAIT) || (state == ST_RECV) || (state == ST_DROP);
    assign beat         = out_tvalid_i && out_tready_o;
    assign hsk_send_o   = (state == ST_ACK);
    assign hsk_type_o   = HSK_ACK;

    assign ctl_rtype_o  = req.rtype;
    assign ctl_rargs_o  = req.rargs;
    assign ctl_value_o  = req.value;
    assign ctl_index_o  = req.index;
    assign ctl_length_o = req.length;

    // Next-state, capture and commit decisions.
    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo_cnt;
        byte_nxt   = byte_cnt;
        crc_nxt    = crc_seen;
        pend_nxt   = pend;
        shadow_nxt = shadow;
        req_nxt    = req;
        start_nxt  = 1'b0;
        err_nxt    = 1'b0;
        take_byte  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (setup_tok) begin
                    state_nxt  = ST_WAIT;
                    tmo_nxt    = '0;
                    byte_nxt   = '0;
                    crc_nxt    = 1'b0;
                    shadow_nxt = '0;
                end
            end
            ST_WAIT, ST_RECV, ST_DROP: begin
                if (setup_tok) begin
                    // A fresh SETUP supersedes whatever was in flight.
                    err_nxt    = 1'b1;
                    state_nxt  = ST_WAIT;
                    tmo_nxt    = '0;
                    byte_nxt   = '0;
                    crc_nxt    = 1'b0;
                    shadow_nxt = '0;
                end else if (state == ST_WAIT) begin
                    if (beat) begin
                        if (out_ttype_i == PID_DATA0) begin
                            state_nxt = ST_RECV;
                            take_byte = 1'b1;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = out_tlast_i ? ST_IDLE : ST_DROP;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        tmo_nxt = tmo_cnt + 1'b1;
                    end
                end else if (state == ST_RECV) begin
                    if (crc_err_i) crc_nxt = 1'b1;
                    take_byte = beat;
                end else begin
                    if (beat && out_tlast_i) state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (setup_tok) pend_nxt = 1'b1;
                if (hsk_sent_i) begin
                    if (pend || setup_tok) begin
                        state_nxt  = ST_WAIT;
                        tmo_nxt    = '0;
                        byte_nxt   = '0;
                        crc_nxt    = 1'b0;
                        shadow_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                    pend_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Data beat: store first 8 bytes, judge the packet on tlast.
        if (take_byte) begin
            if (byte_cnt < 4'd8) shadow_nxt[byte_cnt[2:0]] = out_tdata_i;
            if (byte_cnt != 4'd9) byte_nxt = byte_cnt + 4'd1;
            if (out_tlast_i) begin
                if (byte_cnt == 4'd7 && !crc_seen && !crc_err_i) begin
                    req_nxt   = unpack_req(shadow_nxt);
                    start_nxt = 1'b1;
                    state_nxt = ST_ACK;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            byte_cnt    <= '0;
            crc_seen    <= 1'b0;
            pend        <= 1'b0;
            shadow      <= '0;
            req         <= '0;
            ctl_start_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_nxt;
            byte_cnt    <= byte_nxt;
            crc_seen    <= crc_nxt;
            pend        <= pend_nxt;
            shadow      <= shadow_nxt;
            req         <= req_nxt;
            ctl_start_o <= start_nxt;
            err_o       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ctl_setup_rx.sv
// Bench for ctl_setup_rx: vector table plus hand sequences, events scored
// against a queue of expected start/err outcomes.
module tb_ctl_setup_rx;
    import ctl_setup_rx_pkg::*;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tok_recv_i = 1'b0;
    logic [1:0]  tok_type_i = '0;
    logic        crc_err_i = 1'b0;
    logic        out_tvalid_i = 1'b0;
    logic        out_tready_o;
    logic        out_tlast_i = 1'b0;
    logic [1:0]  out_ttype_i = '0;
    logic [7:0]  out_tdata_i = '0;
    logic        ctl_start_o;
    logic [7:0]  ctl_rtype_o, ctl_rargs_o;
    logic [15:0] ctl_value_o, ctl_index_o, ctl_length_o;
    logic        hsk_send_o;
    logic        hsk_sent_i = 1'b0;
    logic [1:0]  hsk_type_o;
    logic        err_o;

    ctl_setup_rx #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .tok_recv_i(tok_recv_i), .tok_type_i(tok_type_i), .crc_err_i(crc_err_i),
        .out_tvalid_i(out_tvalid_i), .out_tready_o(out_tready_o),
        .out_tlast_i(out_tlast_i), .out_ttype_i(out_ttype_i), .out_tdata_i(out_tdata_i),
        .ctl_start_o(ctl_start_o), .ctl_rtype_o(ctl_rtype_o), .ctl_rargs_o(ctl_rargs_o),
        .ctl_value_o(ctl_value_o), .ctl_index_o(ctl_index_o), .ctl_length_o(ctl_length_o),
        .hsk_send_o(hsk_send_o), .hsk_sent_i(hsk_sent_i), .hsk_type_o(hsk_type_o),
        .err_o(err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [0:9][7:0] data;
        int              n;
        logic [1:0]      pid;
        logic            crc;
        logic            good;
        logic [63:0]     req;   // {rtype, rargs, value, index, length}
    } vec_t;

    typedef struct {
        logic        start;
        logic [63:0] req;
    } exp_t;

    vec_t        vec [8];
    exp_t        sb[$];
    logic [63:0] committed = '0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [63:0] got_req();
        return {ctl_rtype_o, ctl_rargs_o, ctl_value_o, ctl_index_o, ctl_length_o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic good, input logic [63:0] r);
        exp_t e;
        if (good) committed = r;
        e.start = good;
        e.req   = committed;
        sb.push_back(e);
    endtask

    task automatic send_tok(input logic [1:0] t);
        tok_recv_i = 1'b1;
        tok_type_i = t;
        tick();
        tok_recv_i = 1'b0;
        tok_type_i = '0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [1:0] pid,
                             input logic last, input logic crc);
        out_tvalid_i = 1'b1;
        out_tdata_i  = d;
        out_ttype_i  = pid;
        out_tlast_i  = last;
        crc_err_i    = crc;
        tick();
        out_tvalid_i = 1'b0;
        out_tlast_i  = 1'b0;
        crc_err_i    = 1'b0;
    endtask

    task automatic send_pkt(input logic [0:9][7:0] d, input int n);
        for (int j = 0; j < n; j++) send_beat(d[j], PID_DATA0, j == n - 1, 1'b0);
    endtask

    // ACK must be held until the encoder reports it sent.
    task automatic do_ack(input logic pend_exp);
        chk("ack_tready", out_tready_o, 0);
        for (int k = 0; k < 3; k++) begin
            chk("hsk_hold", hsk_send_o, 1);
            chk("hsk_type", hsk_type_o, 0);
            tick();
        end
        hsk_sent_i = 1'b1;
        tick();
        hsk_sent_i = 1'b0;
        chk("hsk_release", hsk_send_o, 0);
        chk("after_ack_tready", out_tready_o, pend_exp);
    endtask

    // Scoreboard: every start/err pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && (ctl_start_o || err_o)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event start=%0b err=%0b", ctl_start_o, err_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ctl_start_o !== e.start || err_o !== !e.start) begin
                    errors++;
                    $display("FAIL event_kind got start=%0b err=%0b exp start=%0b",
                             ctl_start_o, err_o, e.start);
                end
                checks++;
                if (got_req() !== e.req) begin
                    errors++;
                    $display("FAIL event_req got=%0h exp=%0h", got_req(), e.req);
                end
            end
        end
    end

    localparam logic [0:9][7:0] PKT_GET  = {8'h80,8'h06,8'h00,8'h01,8'h00,8'h00,8'h40,8'h00,8'h00,8'h00};
    localparam logic [0:9][7:0] PKT_ADDR = {8'h00,8'h05,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    localparam logic [0:9][7:0] PKT_CLS  = {8'h21,8'h09,8'h00,8'h02,8'h03,8'h00,8'h12,8'h34,8'h00,8'h00};
    localparam logic [0:9][7:0] PKT_LONG = {8'h80,8'h06,8'h00,8'h02,8'h00,8'h00,8'hff,8'h00,8'haa,8'h00};

    initial begin
        vec[0] = '{data: PKT_GET,  n: 8, pid: 2'b00, crc: 1'b0, good: 1'b1,
                   req: {8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040}};
        vec[1] = '{data: PKT_CLS,  n: 7, pid: 2'b00, crc: 1'b0, good: 1'b0, req: '0};
        vec[2] = '{data: PKT_CLS,  n: 8, pid: 2'b00, crc: 1'b1, good: 1'b0, req: '0};
        vec[3] = '{data: PKT_LONG, n: 9, pid: 2'b00, crc: 1'b0, good: 1'b0, req: '0};
        vec[4] = '{data: PKT_CLS,  n: 8, pid: 2'b01, crc: 1'b0, good: 1'b0, req: '0};
        vec[5] = '{data: PKT_CLS,  n: 8, pid: 2'b00, crc: 1'b0, good: 1'b1,
                   req: {8'h21, 8'h09, 16'h0200, 16'h0003, 16'h3412}};
        vec[6] = '{data: PKT_GET,  n: 1, pid: 2'b00, crc: 1'b0, good: 1'b0, req: '0};
        vec[7] = '{data: PKT_ADDR, n: 8, pid: 2'b00, crc: 1'b0, good: 1'b1,
                   req: {8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000}};

        // Reset state
        repeat (3) tick();
        chk("rst_start", ctl_start_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_hsk", hsk_send_o, 0);
        chk("rst_tready", out_tready_o, 0);
        chk("rst_req", got_req(), 0);
        reset = 1'b0;
        tick();

        // Non-SETUP token in IDLE is ignored
        send_tok(2'b01);
        chk("nonsetup_idle", out_tready_o, 0);

        // Table of packets: good, short, CRC, long, DATA1, good, 1-byte, good
        for (int i = 0; i < 8; i++) begin
            push(vec[i].good, vec[i].req);
            send_tok(TOK_SETUP);
            chk("wait_tready", out_tready_o, 1);
            for (int j = 0; j < vec[i].n; j++)
                send_beat(vec[i].data[j], vec[i].pid, j == vec[i].n - 1,
                          vec[i].crc && (j == vec[i].n - 1));
            if (vec[i].good) do_ack(1'b0);
            else begin
                chk("bad_no_hsk", hsk_send_o, 0);
                chk("bad_idle", out_tready_o, 0);
                chk("bad_keep_req", got_req(), committed);
            end
            tick();
        end

        // Second SETUP mid-packet aborts, then the new request completes
        push(1'b0, '0);
        push(1'b1, {8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000});
        send_tok(TOK_SETUP);
        for (int j = 0; j < 3; j++) send_beat(PKT_GET[j], PID_DATA0, 1'b0, 1'b0);
        send_tok(TOK_SETUP);
        send_pkt(PKT_ADDR, 8);
        do_ack(1'b0);
        tick();

        // Timeout with no data
        push(1'b0, '0);
        send_tok(TOK_SETUP);
        repeat (TMO - 1) tick();
        chk("tmo_not_early", err_o, 0);
        chk("tmo_still_wait", out_tready_o, 1);
        tick();
        chk("tmo_err", err_o, 1);
        tick();
        chk("tmo_idle", out_tready_o, 0);

        // Non-SETUP token mid-packet is ignored
        push(1'b1, {8'h21, 8'h09, 16'h0200, 16'h0003, 16'h3412});
        send_tok(TOK_SETUP);
        for (int j = 0; j < 8; j++) begin
            if (j == 4) begin
                tok_recv_i = 1'b1;
                tok_type_i = 2'b10;
            end
            send_beat(PKT_CLS[j], PID_DATA0, j == 7, 1'b0);
            tok_recv_i = 1'b0;
            tok_type_i = '0;
        end
        do_ack(1'b0);
        tick();

        // SETUP during ACK is latched and honoured after hsk_sent
        push(1'b1, {8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040});
        send_tok(TOK_SETUP);
        send_pkt(PKT_GET, 8);
        send_tok(TOK_SETUP);
        send_tok(2'b01);
        chk("ack_hold_pend", hsk_send_o, 1);
        do_ack(1'b1);
        push(1'b1, {8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000});
        send_pkt(PKT_ADDR, 8);
        do_ack(1'b0);
        tick();

        // Reset at byte 4, trailing bytes ignored, then a clean request
        send_tok(TOK_SETUP);
        for (int j = 0; j < 4; j++) send_beat(PKT_CLS[j], PID_DATA0, 1'b0, 1'b0);
        out_tvalid_i = 1'b1;
        out_tdata_i  = PKT_CLS[4];
        reset = 1'b1;
        tick();
        chk("midrst_start", ctl_start_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_hsk", hsk_send_o, 0);
        chk("midrst_tready", out_tready_o, 0);
        chk("midrst_req", got_req(), 0);
        committed = '0;
        reset = 1'b0;
        out_tvalid_i = 1'b0;
        for (int j = 5; j < 8; j++) send_beat(PKT_CLS[j], PID_DATA0, j == 7, 1'b0);
        hsk_sent_i = 1'b1;
        tick();
        hsk_sent_i = 1'b0;
        chk("postrst_idle", out_tready_o, 0);
        chk("postrst_req", got_req(), 0);
        push(1'b1, {8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040});
        send_tok(TOK_SETUP);
        send_pkt(PKT_GET, 8);
        do_ack(1'b0);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
